// File: rtl/eth_echo_responder_pkg.sv
// Shared constants, state encoding and request-match helper for eth_echo_responder.
package eth_echo_responder_pkg;

  localparam logic [15:0] ECHO_TYPE_DEF  = 16'h88B5;
  localparam logic [15:0] REPLY_TYPE_DEF = 16'h88B6;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    HDR_OUT,
    FWD,
    DROP
  } state_t;

  function automatic logic frame_match(
    input logic [15:0] etype,
    input logic [47:0] dest,
    input logic [47:0] mac,
    input logic [15:0] want_type,
    input logic        bcast_ok
  );
    return (etype == want_type) &&
           ((dest == mac) || (bcast_ok && (dest == BCAST_MAC)));
  endfunction

endpackage

// File: rtl/eth_echo_responder.sv
// Echo responder: returns matching request frames with swapped MACs and reply ethertype.
// Optional timestamp insertion into the payload is enabled by RESPONDER_TIMESTAMP_EN.
module eth_echo_responder
  import eth_echo_responder_pkg::*;
#(
  parameter logic [15:0] ECHO_TYPE    = ECHO_TYPE_DEF,
  parameter logic [15:0] REPLY_TYPE   = REPLY_TYPE_DEF,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int unsigned TS_OFFSET    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_mac,
  input  logic [15:0] timestamp,

  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic        s_eth_payload_axis_tready,

  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [7:0]  m_eth_payload_axis_tdata,
  output logic        m_eth_payload_axis_tvalid,
  output logic        m_eth_payload_axis_tlast,
  output logic        m_eth_payload_axis_tuser,
  input  logic        m_eth_payload_axis_tready,

  output logic [15:0] echo_count,
  output logic [15:0] drop_count,
  output logic        busy
);

  state_t     state, state_nxt;
  logic       match;
  logic [7:0] fwd_data;

  assign match = frame_match(s_eth_type, s_eth_dest_mac, local_mac, ECHO_TYPE, ACCEPT_BCAST);

  always_comb begin
    state_nxt                 = state;
    s_eth_hdr_ready           = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
    m_eth_hdr_valid           = 1'b0;
    m_eth_payload_axis_tvalid = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so no header is taken in a reset cycle.
        s_eth_hdr_ready = rst_n;
        if (s_eth_hdr_valid) state_nxt = match ? HDR_OUT : DROP;
      end
      HDR_OUT: begin
        m_eth_hdr_valid = 1'b1;
        if (m_eth_hdr_ready) state_nxt = FWD;
      end
      FWD: begin
        m_eth_payload_axis_tvalid = s_eth_payload_axis_tvalid;
        s_eth_payload_axis_tready = m_eth_payload_axis_tready;
        if (s_eth_payload_axis_tvalid && m_eth_payload_axis_tready && s_eth_payload_axis_tlast)
          state_nxt = IDLE;
      end
      DROP: begin
        s_eth_payload_axis_tready = 1'b1;
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      m_eth_dest_mac <= '0;
      m_eth_src_mac  <= '0;
      m_eth_type     <= '0;
      echo_count     <= '0;
      drop_count     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && s_eth_hdr_valid && match) begin
        m_eth_dest_mac <= s_eth_src_mac;
        m_eth_src_mac  <= local_mac;
        m_eth_type     <= REPLY_TYPE;
      end
      if (state == FWD && s_eth_payload_axis_tvalid && m_eth_payload_axis_tready &&
          s_eth_payload_axis_tlast)
        echo_count <= echo_count + 16'd1;
      if (state == DROP && s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast)
        drop_count <= drop_count + 16'd1;
    end
  end

`ifdef RESPONDER_TIMESTAMP_EN
  localparam logic [10:0] TS_IDX = 11'(TS_OFFSET);

  logic [15:0] ts_q;
  logic [10:0] byte_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q     <= '0;
      byte_idx <= '0;
    end else begin
      if (s_eth_hdr_valid && s_eth_hdr_ready) ts_q <= timestamp;
      if (m_eth_hdr_valid && m_eth_hdr_ready)
        byte_idx <= '0;
      else if (state == FWD && s_eth_payload_axis_tvalid && m_eth_payload_axis_tready)
        byte_idx <= byte_idx + 11'd1;
    end
  end

  always_comb begin
    fwd_data = s_eth_payload_axis_tdata;
    if (byte_idx == TS_IDX)
      fwd_data = ts_q[15:8];
    else if (byte_idx == TS_IDX + 11'd1)
      fwd_data = ts_q[7:0];
  end
`else
  logic unused_ts;
  assign unused_ts = ^{timestamp, 32'(TS_OFFSET)};
  assign fwd_data  = s_eth_payload_axis_tdata;
`endif

  assign m_eth_payload_axis_tdata = fwd_data;
  assign m_eth_payload_axis_tlast = s_eth_payload_axis_tlast;
  assign m_eth_payload_axis_tuser = s_eth_payload_axis_tuser;
  assign busy                     = (state != IDLE);

endmodule

// File: tb/tb_eth_echo_responder.sv
// Directed self-checking bench for eth_echo_responder (main instance plus a no-broadcast instance).
`timescale 1ns/1ps
module tb_eth_echo_responder;

  localparam logic [15:0] ECHO  = 16'h88B5;
  localparam logic [15:0] REPLY = 16'h88B6;
  localparam logic [47:0] LMAC  = 48'h07_08_09_0A_0B_0C;
  localparam logic [47:0] SRC1  = 48'h01_02_03_04_05_06;
  localparam logic [47:0] SRC2  = 48'h11_22_33_44_55_66;
  localparam logic [47:0] BC    = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst_n;
  logic [47:0] local_mac;
  logic [15:0] timestamp;
  logic        hv, sel, bp_en;
  logic [47:0] s_dest, s_src;
  logic [15:0] s_type;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;

  logic a_hdr_valid, a_tvalid, a_hdr_ready, a_tready;
  logic b_hdr_valid, b_tvalid, b_hdr_ready, b_tready;
  logic eff_hdr_ready, eff_tready;

  logic        m_hdr_valid, m_hdr_ready;
  logic [47:0] m_dest, m_src;
  logic [15:0] m_type;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic [15:0] echo_count, drop_count;
  logic        busy;

  logic        b_m_hdr_valid, b_m_tvalid, b_busy;
  logic [47:0] unused_b_dest, unused_b_src;
  logic [15:0] unused_b_type, b_echo_count, b_drop_count;
  logic [7:0]  unused_b_tdata;
  logic        unused_b_tlast, unused_b_tuser;

  assign a_hdr_valid   = hv & ~sel;
  assign b_hdr_valid   = hv & sel;
  assign a_tvalid      = s_tvalid & ~sel;
  assign b_tvalid      = s_tvalid & sel;
  assign eff_hdr_ready = sel ? b_hdr_ready : a_hdr_ready;
  assign eff_tready    = sel ? b_tready : a_tready;

  eth_echo_responder #(.TS_OFFSET(4)) dut (
    .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .timestamp(timestamp),
    .s_eth_hdr_valid(a_hdr_valid), .s_eth_hdr_ready(a_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(a_tvalid),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .s_eth_payload_axis_tready(a_tready),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tvalid(m_tvalid),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .m_eth_payload_axis_tready(m_tready),
    .echo_count(echo_count), .drop_count(drop_count), .busy(busy)
  );

  eth_echo_responder #(.ACCEPT_BCAST(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .timestamp(timestamp),
    .s_eth_hdr_valid(b_hdr_valid), .s_eth_hdr_ready(b_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(b_tvalid),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .s_eth_payload_axis_tready(b_tready),
    .m_eth_hdr_valid(b_m_hdr_valid), .m_eth_hdr_ready(1'b1),
    .m_eth_dest_mac(unused_b_dest), .m_eth_src_mac(unused_b_src), .m_eth_type(unused_b_type),
    .m_eth_payload_axis_tdata(unused_b_tdata), .m_eth_payload_axis_tvalid(b_m_tvalid),
    .m_eth_payload_axis_tlast(unused_b_tlast), .m_eth_payload_axis_tuser(unused_b_tuser),
    .m_eth_payload_axis_tready(1'b1),
    .echo_count(b_echo_count), .drop_count(b_drop_count), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]   rx_data[$];
  logic         rx_last[$];
  logic         rx_user[$];
  logic [111:0] hq[$];
  int           b_hv_seen, b_tv_seen;
  logic [111:0] hold_hdr;
  logic         holding = 1'b0;

  // Expected reply byte: payload pattern, with the timestamp bytes when insertion is built in.
  function automatic logic [7:0] exp_byte(input logic [7:0] base, input int i);
`ifdef RESPONDER_TIMESTAMP_EN
    if (i == 4) return timestamp[15:8];
    if (i == 5) return timestamp[7:0];
`endif
    return 8'(base + 8'(i));
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        rx_data.push_back(m_tdata);
        rx_last.push_back(m_tlast);
        rx_user.push_back(m_tuser);
      end
      if (m_hdr_valid === 1'b1 && m_hdr_ready === 1'b1) hq.push_back({m_dest, m_src, m_type});
      if (b_m_hdr_valid === 1'b1) b_hv_seen++;
      if (b_m_tvalid === 1'b1) b_tv_seen++;
      if (m_hdr_valid === 1'b1 && m_tvalid === 1'b1) begin
        errors++;
        $display("FAIL valid_overlap: hdr_valid and tvalid both high at %0t", $time);
      end
      if (m_hdr_valid === 1'b1) begin
        if (holding) begin
          checks++;
          if ({m_dest, m_src, m_type} !== hold_hdr) begin
            errors++;
            $display("FAIL hdr_stable: got %h want %h", {m_dest, m_src, m_type}, hold_hdr);
          end
        end
        holding  = (m_hdr_ready !== 1'b1);
        hold_hdr = {m_dest, m_src, m_type};
      end else holding = 1'b0;
    end else holding = 1'b0;
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rx_data.delete(); rx_last.delete(); rx_user.delete(); hq.delete();
    b_hv_seen = 0; b_tv_seen = 0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Starts and ends at 1 time unit after a rising edge.
  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int n, input logic [7:0] base, input logic user,
                            output int stalls);
    int to;
    stalls = 0;
    s_dest = d; s_src = s; s_type = t; hv = 1'b1;
    to = 0;
    @(negedge clk);
    while (eff_hdr_ready !== 1'b1 && to < 200) begin to++; @(negedge clk); end
    if (to >= 200) begin errors++; $display("FAIL hdr_timeout: ready=%b want 1", eff_hdr_ready); end
    @(posedge clk); #1;
    hv = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_tdata = 8'(base + 8'(i)); s_tvalid = 1'b1; s_tlast = (i == n - 1); s_tuser = user;
      to = 0;
      @(negedge clk);
      while (eff_tready !== 1'b1 && to < 200) begin to++; stalls++; @(negedge clk); end
      if (to >= 200) begin errors++; $display("FAIL beat_timeout: beat %0d tready=%b want 1", i, eff_tready); end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hv = 1'b0; sel = 1'b0; bp_en = 1'b0; m_hdr_ready = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = '0;
    s_dest = '0; s_src = '0; s_type = '0;
    local_mac = LMAC; timestamp = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (a_hdr_ready !== 1'b0) begin errors++; $display("FAIL rst_hdr_ready: got %b want 0", a_hdr_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (m_hdr_valid !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_valids: hdr=%b t=%b want 0 0", m_hdr_valid, m_tvalid); end
    checks++; if (echo_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL rst_counts: echo=%0d drop=%0d want 0 0", echo_count, drop_count); end
    checks++; if ({m_dest, m_src, m_type} !== 112'd0) begin errors++; $display("FAIL rst_hdr_regs: got %h want 0", {m_dest, m_src, m_type}); end
    checks++; if (a_hdr_ready !== 1'b1) begin errors++; $display("FAIL idle_hdr_ready: got %b want 1", a_hdr_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_echo();
    int st;
    clear_mon();
    send_frame(LMAC, SRC1, ECHO, 64, 8'h00, 1'b0, st);
    settle();
    checks++; if (hq.size() != 1) begin errors++; $display("FAIL echo_hdr_count: got %0d want 1", hq.size()); end
    else begin
      checks++;
      if (hq[0] !== {SRC1, LMAC, REPLY}) begin errors++; $display("FAIL echo_hdr: got %h want %h", hq[0], {SRC1, LMAC, REPLY}); end
    end
    checks++; if (rx_data.size() != 64) begin errors++; $display("FAIL echo_len: got %0d want 64", rx_data.size()); end
    else for (int i = 0; i < 64; i++) begin
      checks++;
      if (rx_data[i] !== exp_byte(8'h00, i) || rx_last[i] !== (i == 63)) begin
        errors++; $display("FAIL echo_byte[%0d]: got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_byte(8'h00, i), (i == 63));
      end
    end
    checks++; if (echo_count !== 16'd1) begin errors++; $display("FAIL echo_count: got %0d want 1", echo_count); end
  endtask

  task automatic test_drop();
    int st;
    clear_mon();
    send_frame(LMAC, SRC1, 16'h0800, 64, 8'h00, 1'b0, st);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
    settle();
    checks++; if (st != 0) begin errors++; $display("FAIL drop_stalls: got %0d want 0", st); end
    checks++; if (hq.size() != 0 || rx_data.size() != 0) begin errors++; $display("FAIL drop_output: hdrs=%0d beats=%0d want 0 0", hq.size(), rx_data.size()); end
    checks++; if (drop_count !== 16'd1 || echo_count !== 16'd1) begin errors++; $display("FAIL drop_count: drop=%0d echo=%0d want 1 1", drop_count, echo_count); end
  endtask

  task automatic test_bcast();
    int st;
    clear_mon();
    send_frame(BC, SRC2, ECHO, 8, 8'h40, 1'b0, st);
    settle();
    checks++; if (hq.size() != 1 || rx_data.size() != 8) begin errors++; $display("FAIL bcast_echo: hdrs=%0d beats=%0d want 1 8", hq.size(), rx_data.size()); end
    else begin
      checks++; if (hq[0] !== {SRC2, LMAC, REPLY}) begin errors++; $display("FAIL bcast_hdr: got %h want %h", hq[0], {SRC2, LMAC, REPLY}); end
    end
    checks++; if (echo_count !== 16'd2) begin errors++; $display("FAIL bcast_echo_count: got %0d want 2", echo_count); end
    sel = 1'b1;
    send_frame(BC, SRC2, ECHO, 8, 8'h50, 1'b0, st);
    settle();
    sel = 1'b0;
    checks++; if (b_drop_count !== 16'd1 || b_echo_count !== 16'd0) begin errors++; $display("FAIL nobcast_counts: drop=%0d echo=%0d want 1 0", b_drop_count, b_echo_count); end
    checks++; if (b_hv_seen != 0 || b_tv_seen != 0 || b_busy !== 1'b0) begin errors++; $display("FAIL nobcast_output: hv=%0d tv=%0d busy=%b want 0 0 0", b_hv_seen, b_tv_seen, b_busy); end
    checks++; if (rx_data.size() != 8) begin errors++; $display("FAIL nobcast_main_quiet: beats=%0d want 8", rx_data.size()); end
  endtask

  task automatic test_single_byte();
    int st;
    clear_mon();
    send_frame(LMAC, SRC1, ECHO, 1, 8'hEE, 1'b1, st);
    settle();
    checks++; if (rx_data.size() != 1) begin errors++; $display("FAIL single_len: got %0d want 1", rx_data.size()); end
    else begin
      checks++;
      if (rx_data[0] !== 8'hEE || rx_last[0] !== 1'b1 || rx_user[0] !== 1'b1) begin
        errors++; $display("FAIL single_beat: got %h/%b/%b want ee/1/1", rx_data[0], rx_last[0], rx_user[0]);
      end
    end
    checks++; if (echo_count !== 16'd3) begin errors++; $display("FAIL single_echo_count: got %0d want 3", echo_count); end
    send_frame(LMAC, SRC1, 16'h86DD, 1, 8'h77, 1'b0, st);
    settle();
    checks++; if (drop_count !== 16'd2 || rx_data.size() != 1) begin errors++; $display("FAIL single_drop: drop=%0d beats=%0d want 2 1", drop_count, rx_data.size()); end
  endtask

  task automatic test_back_to_back();
    int st;
    clear_mon();
    send_frame(LMAC, SRC1, ECHO, 4, 8'h10, 1'b0, st);
    send_frame(LMAC, SRC2, ECHO, 5, 8'h20, 1'b0, st);
    settle();
    checks++; if (hq.size() != 2 || rx_data.size() != 9) begin errors++; $display("FAIL b2b_counts: hdrs=%0d beats=%0d want 2 9", hq.size(), rx_data.size()); end
    else begin
      checks++; if (hq[1] !== {SRC2, LMAC, REPLY}) begin errors++; $display("FAIL b2b_hdr2: got %h want %h", hq[1], {SRC2, LMAC, REPLY}); end
      checks++; if (rx_data[4] !== 8'h20 || rx_last[3] !== 1'b1) begin errors++; $display("FAIL b2b_boundary: got %h/%b want 20/1", rx_data[4], rx_last[3]); end
    end
    checks++; if (echo_count !== 16'd5) begin errors++; $display("FAIL b2b_echo_count: got %0d want 5", echo_count); end
  endtask

  task automatic test_backpressure();
    int st;
    clear_mon();
    m_hdr_ready = 1'b0;
    bp_en = 1'b1;
    fork
      send_frame(LMAC, SRC2, ECHO, 32, 8'hA0, 1'b0, st);
      begin
        int to = 0;
        @(negedge clk);
        while (m_hdr_valid !== 1'b1 && to < 100) begin to++; @(negedge clk); end
        repeat (10) @(negedge clk);
        checks++;
        if (m_hdr_valid !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_hdr_hold: hdr=%b t=%b want 1 0", m_hdr_valid, m_tvalid); end
        @(posedge clk); #1 m_hdr_ready = 1'b1;
      end
    join
    bp_en = 1'b0;
    settle();
    checks++; if (hq.size() != 1 || rx_data.size() != 32) begin errors++; $display("FAIL bp_counts: hdrs=%0d beats=%0d want 1 32", hq.size(), rx_data.size()); end
    else for (int i = 0; i < 32; i++) begin
      checks++;
      if (rx_data[i] !== exp_byte(8'hA0, i)) begin errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, rx_data[i], exp_byte(8'hA0, i)); end
    end
    checks++; if (echo_count !== 16'd6) begin errors++; $display("FAIL bp_echo_count: got %0d want 6", echo_count); end
  endtask

  task automatic test_reset_mid();
    int st;
    int to = 0;
    clear_mon();
    s_dest = LMAC; s_src = SRC1; s_type = ECHO; hv = 1'b1;
    @(negedge clk);
    while (a_hdr_ready !== 1'b1 && to < 50) begin to++; @(negedge clk); end
    @(posedge clk); #1 hv = 1'b0;
    s_tdata = 8'h5A; s_tvalid = 1'b1; s_tlast = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_in_fwd: busy=%b tvalid=%b want 1 1", busy, m_tvalid); end
    @(posedge clk); #1;
    rst_n = 1'b0; s_tvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || m_hdr_valid !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_after_rst: busy=%b hdr=%b t=%b want 0 0 0", busy, m_hdr_valid, m_tvalid); end
    checks++; if (echo_count !== 16'd0) begin errors++; $display("FAIL mid_count_clr: got %0d want 0", echo_count); end
    @(posedge clk); #1;
    clear_mon();
    send_frame(LMAC, SRC1, ECHO, 16, 8'h30, 1'b0, st);
    settle();
    checks++; if (hq.size() != 1 || rx_data.size() != 16 || echo_count !== 16'd1) begin errors++; $display("FAIL mid_recover: hdrs=%0d beats=%0d echo=%0d want 1 16 1", hq.size(), rx_data.size(), echo_count); end
    else begin
      checks++; if (rx_data[0] !== 8'h30 || rx_data[15] !== exp_byte(8'h30, 15)) begin errors++; $display("FAIL mid_recover_data: got %h..%h want 30..%h", rx_data[0], rx_data[15], exp_byte(8'h30, 15)); end
    end
  endtask

`ifdef RESPONDER_TIMESTAMP_EN
  task automatic test_timestamp();
    int st;
    logic [7:0] want8 [8];
    want8 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h12, 8'h34, 8'h06, 8'h07};
    timestamp = 16'h1234;
    clear_mon();
    send_frame(LMAC, SRC1, ECHO, 8, 8'h00, 1'b0, st);
    settle();
    checks++; if (rx_data.size() != 8) begin errors++; $display("FAIL ts_len: got %0d want 8", rx_data.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_data[i] !== want8[i]) begin errors++; $display("FAIL ts_byte[%0d]: got %h want %h", i, rx_data[i], want8[i]); end
    end
    clear_mon();
    send_frame(LMAC, SRC1, ECHO, 3, 8'h00, 1'b0, st);
    settle();
    checks++; if (rx_data.size() != 3) begin errors++; $display("FAIL ts_short_len: got %0d want 3", rx_data.size()); end
    else begin
      checks++;
      if (rx_data[0] !== 8'h00 || rx_data[1] !== 8'h01 || rx_data[2] !== 8'h02) begin
        errors++; $display("FAIL ts_short: got %h %h %h want 00 01 02", rx_data[0], rx_data[1], rx_data[2]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_echo();
    test_drop();
    test_bcast();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef RESPONDER_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
